cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
//  Instruction sequencer for the 8-bit RISC CPU. It steps an 8-phase fetch/execute cycle and drives the
//  strobes that steer the ALU, IR, PC, accumulator and memory bus. Opcode comes from the IR; zero comes
//  from the ALU is_zero output. One instruction completes every 8 clocks; HLT parks the core until reset.
// PARAMETERS
//  OPCODE   3  opcode width (encoding below is fixed for 3)
//  PHASE_W  3  phase counter width (8 phases)
// PORTS
//  clk     in   1       system clock, rising edge
//  rst     in   1       asynchronous, active-high reset
//  opcode  in   OPCODE  IR[7:5]; 000 HLT,001 SKZ,010 ADD,011 AND,100 XOR,101 LDA,110 STO,111 JMP
//  zero    in   1       ALU is_zero (accumulator == 0)
//  sel     out  1       address mux: 1=PC, 0=IR operand field
//  rd      out  1       memory read enable
//  ld_ir   out  1       load instruction register
//  inc_pc  out  1       PC increment strobe
//  ld_pc   out  1       PC load from IR operand (jump)
//  ld_ac   out  1       load accumulator from ALU out
//  wr      out  1       memory write strobe
//  data_e  out  1       drive accumulator onto data bus
//  halt    out  1       core halted
//  phase   out  PHASE_W current phase, debug/trace
// BEHAVIOUR
//  - State: phase counter 0..7 plus HALTED flag. Outputs are combinational from state, opcode and zero.
//  - Reset (async, any time, incl. mid-instruction): phase=0, HALTED=0; outputs = phase-0 decode (sel=1, rest 0).
//  - Phase advances +1 each clock when not HALTED; 7 wraps to 0 (next fetch). No stalls.
//  - ALUOP = ADD|AND|XOR|LDA.
//  - Per phase (unlisted outputs 0):
//    0 INST_ADDR : sel
//    1 INST_FETCH: sel, rd
//    2 INST_LOAD : sel, rd, ld_ir
//    3 IDLE      : sel, rd, ld_ir
//    4 OP_ADDR   : inc_pc; halt = (opcode==HLT)
//    5 OP_FETCH  : rd = ALUOP
//    6 ALU_OP    : rd = ALUOP; inc_pc = SKZ & zero; ld_pc = JMP; data_e = STO
//    7 STORE     : rd = ALUOP; ld_ac = ALUOP; ld_pc = JMP; wr = STO; data_e = STO
//  - HLT: at the clock edge ending phase 4 with opcode==HLT, set HALTED, phase freezes at 4.
//    HALTED: halt=1, every other strobe 0, phase holds 4; leaves only via rst.
//  - opcode is sampled only in phases 4..7 (IR stable); in phases 0..3 it is don't-care.
//  - zero is used only in phase 6 (SKZ); a zero change in other phases has no effect.
//  - wr and data_e are never asserted in phases 0..5; ld_ir and rd never overlap wr.
//  - inc_pc is asserted at most twice per instruction (phase 4; phase 6 only for SKZ taken).
//  - Unknown/X opcode in phases 4..7 is not defined; the bench checks only legal opcodes.
// TESTING
//  1 Reset: rst=1 mid phase 5 -> same cycle phase=0, sel=1, all other strobes 0; after release, phase counts 0..7.
//  2 ADD (opcode=010): phases 5,6,7 -> rd=1; phase 7 ld_ac=1; wr=0, ld_pc=0; one inc_pc pulse (phase 4).
//  3 STO (110): phase 6 data_e=1, wr=0; phase 7 wr=1, data_e=1; rd=0 in phases 5..7.
//  4 SKZ (001): zero=1 -> inc_pc in phases 4 and 6 (2 pulses); zero=0 -> phase 4 only.
//  5 JMP (111): ld_pc=1 in phases 6 and 7; ld_ac=0, wr=0; phase wraps 7->0 next clock.
//  6 HLT (000): phase 4 halt=1; 20 further clocks -> phase stays 4, halt=1, all other strobes 0; rst restarts at phase 0.

Source files
------------

// File: rtl/cpu_controller.sv
// Instruction sequencer for the 8-bit RISC CPU: an 8-phase fetch/execute
// counter with a sticky halt, decoding bus/register strobes from phase, opcode and zero.
module cpu_controller #(
  parameter int OPCODE  = 3,
  parameter int PHASE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPCODE-1:0]  opcode,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               ld_ac,
  output logic               wr,
  output logic               data_e,
  output logic               halt,
  output logic [PHASE_W-1:0] phase
);

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [OPCODE-1:0] OP_HLT = 3'b000;
  localparam logic [OPCODE-1:0] OP_SKZ = 3'b001;
  localparam logic [OPCODE-1:0] OP_ADD = 3'b010;
  localparam logic [OPCODE-1:0] OP_AND = 3'b011;
  localparam logic [OPCODE-1:0] OP_XOR = 3'b100;
  localparam logic [OPCODE-1:0] OP_LDA = 3'b101;
  localparam logic [OPCODE-1:0] OP_STO = 3'b110;
  localparam logic [OPCODE-1:0] OP_JMP = 3'b111;

  phase_t phase_r;
  logic   halted_r;
  logic   aluop_s;

  // Phase sequencing; a HLT seen at the end of OP_ADDR freezes the core there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r  <= INST_ADDR;
      halted_r <= 1'b0;
    end else if (halted_r) begin
      phase_r  <= phase_r;
      halted_r <= 1'b1;
    end else if ((phase_r == OP_ADDR) && (opcode == OP_HLT)) begin
      phase_r  <= phase_r;
      halted_r <= 1'b1;
    end else begin
      phase_r  <= phase_t'(phase_r + 3'd1);
      halted_r <= 1'b0;
    end
  end

  assign aluop_s = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

  // Strobe decode; opcode only matters from OP_ADDR onward, zero only in ALU_OP.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_r) begin
      halt = 1'b1;
    end else begin
      case (phase_r)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: begin
          rd = aluop_s;
        end
        ALU_OP: begin
          rd     = aluop_s;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = aluop_s;
          ld_ac  = aluop_s;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase = phase_r;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus pushes hand-written expected
// strobe vectors; a monitor pops and compares them at the falling edge.
module tb_cpu_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  cpu_controller #(.OPCODE(3), .PHASE_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  // vector order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
  typedef struct packed {
    logic [2:0] ph;
    logic [8:0] v;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  event  check_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares one queued expectation per falling edge or explicit request.
  initial begin
    exp_t       e;
    string      nm;
    logic [8:0] act;
    forever begin
      @(negedge clk or check_ev);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
        checks++;
        if (act !== e.v || phase !== e.ph) begin
          failures++;
          $display("FAIL %s: phase=%0d strobes=%b, required phase=%0d strobes=%b",
                   nm, phase, act, e.ph, e.v);
        end
      end
    end
  end

  function automatic logic [8:0] fetch_vec(input int p);
    case (p)
      0:       fetch_vec = 9'b100000000;
      1:       fetch_vec = 9'b110000000;
      2:       fetch_vec = 9'b111000000;
      3:       fetch_vec = 9'b111000000;
      default: fetch_vec = 9'b000100000;
    endcase
  endfunction

  task automatic push(input logic [2:0] ph, input logic [8:0] v, input string nm);
    exp_t e;
    e.ph = ph;
    e.v  = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input logic [2:0] ph, input logic [8:0] v, input string nm);
    push(ph, v, nm);
    @(posedge clk);
    #1;
  endtask

  // Full instruction; opcode is garbage in fetch phases, zero inverted outside phase 6.
  task automatic run_instr(input logic [2:0] op, input logic z, input string nm,
                           input logic [8:0] e5, input logic [8:0] e6, input logic [8:0] e7);
    logic [8:0] e;
    for (int p = 0; p < 8; p++) begin
      opcode = (p < 4) ? ~op : op;
      zero   = (p == 6) ? z : ~z;
      case (p)
        5:       e = e5;
        6:       e = e6;
        7:       e = e7;
        default: e = fetch_vec(p);
      endcase
      step(3'(p), e, $sformatf("%s_ph%0d", nm, p));
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 3'b000; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(3'd0, 9'b100000000, "reset_state");
    rst = 1'b0;

    run_instr(3'b010, 1'b0, "add", 9'b010000000, 9'b010000000, 9'b010001000);
    run_instr(3'b011, 1'b1, "and", 9'b010000000, 9'b010000000, 9'b010001000);
    run_instr(3'b100, 1'b0, "xor", 9'b010000000, 9'b010000000, 9'b010001000);
    run_instr(3'b101, 1'b1, "lda", 9'b010000000, 9'b010000000, 9'b010001000);
    run_instr(3'b110, 1'b1, "sto", 9'b000000000, 9'b000000010, 9'b000000110);
    run_instr(3'b001, 1'b1, "skz_taken", 9'b000000000, 9'b000100000, 9'b000000000);
    run_instr(3'b001, 1'b0, "skz_not", 9'b000000000, 9'b000000000, 9'b000000000);
    run_instr(3'b111, 1'b1, "jmp", 9'b000000000, 9'b000010000, 9'b000010000);

    // Asynchronous reset in the middle of phase 5.
    opcode = 3'b010;
    for (int p = 0; p < 5; p++) step(3'(p), fetch_vec(p), $sformatf("pre_rst_ph%0d", p));
    push(3'd5, 9'b010000000, "pre_rst_ph5");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    push(3'd0, 9'b100000000, "async_rst");
    ->check_ev;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(3'b010, 1'b0, "add_after_rst", 9'b010000000, 9'b010000000, 9'b010001000);

    // HLT parks the core in phase 4 regardless of opcode/zero.
    opcode = 3'b000;
    for (int p = 0; p < 4; p++) step(3'(p), fetch_vec(p), $sformatf("hlt_ph%0d", p));
    step(3'd4, 9'b000100001, "hlt_ph4");
    for (int i = 0; i < 20; i++) begin
      opcode = 3'(i);
      zero   = i[0];
      step(3'd4, 9'b000000001, $sformatf("halted_%0d", i));
    end
    rst = 1'b1;
    step(3'd0, 9'b100000000, "halt_rst");
    rst = 1'b0;
    run_instr(3'b111, 1'b0, "jmp_after_halt", 9'b000000000, 9'b000010000, 9'b000010000);
    step(3'd0, 9'b100000000, "wrap_to_0");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
